// File: rtl/cc_line_fill_unit.sv
// -----------------------------------------------------------------------------
// cc_line_fill_unit
//
// Purpose:
//   Collects the R-channel beats of a wrapping, critical-word-first cache line
//   refill. The beats are placed in their line slots using the miss address
//   at the head of the miss-address FIFO. One SRAM line write (tag + data) is
//   issued per burst. The unit also forwards the critical word early,
//   invalidates lines that return with error responses, and flags burst-length
//   protocol violations.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_rdata_i              R beat data (BEAT_W)
//   mem_rresp_i              R beat response; bit 1 marks SLVERR/DECERR
//   mem_rlast_i              R last-beat marker
//   mem_rvalid_i             R valid
//   mem_rready_i             R ready (driven elsewhere; observed only)
//   miss_addr_fifo_empty_i   miss FIFO empty
//   miss_addr_fifo_rdata_i   show-ahead head of the miss FIFO
//   miss_addr_fifo_rden_o    pop the miss FIFO (combinational, final beat)
//   wren_o                   SRAM line write enable (1-cycle pulse)
//   waddr_o                  SRAM index
//   wdata_tag_o              {valid, tag}
//   wdata_data_o             full line data
//   crit_valid_o             1-cycle pulse: critical word available
//   crit_data_o              critical word (held until next critical beat)
//   fill_err_o               pulses with wren_o when the line is invalidated
//   proto_err_o              sticky protocol-error flag
// -----------------------------------------------------------------------------
module cc_line_fill_unit #(
   parameter int ADDR_W     = 32,
   parameter int BEAT_W     = 64,
   parameter int LINE_BYTES = 64,
   parameter int IDX_W      = 9
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [BEAT_W-1:0]                      mem_rdata_i,
   input  logic [1:0]                             mem_rresp_i,
   input  logic                                   mem_rlast_i,
   input  logic                                   mem_rvalid_i,
   input  logic                                   mem_rready_i,
   input  logic                                   miss_addr_fifo_empty_i,
   input  logic [ADDR_W-1:0]                      miss_addr_fifo_rdata_i,
   output logic                                   miss_addr_fifo_rden_o,
   output logic                                   wren_o,
   output logic [IDX_W-1:0]                       waddr_o,
   output logic [ADDR_W-IDX_W-$clog2(LINE_BYTES):0] wdata_tag_o,
   output logic [LINE_BYTES*8-1:0]                wdata_data_o,
   output logic                                   crit_valid_o,
   output logic [BEAT_W-1:0]                      crit_data_o,
   output logic                                   fill_err_o,
   output logic                                   proto_err_o
);

   localparam int WOFF   = $clog2(BEAT_W / 8);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int BEATS  = LINE_BYTES * 8 / BEAT_W;
   localparam int BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = LINE_BYTES * 8;
   localparam logic [BI_W-1:0] LAST_K = BI_W'(BEATS - 1);

   // Burst-tracking state
   logic [BI_W-1:0]   beat_cnt;
   logic              err_acc;
   logic [LINE_W-1:0] line_buf;

   // Registered outputs (one cycle after the accepting beat)
   logic              wr_vld_p1;
   logic [IDX_W-1:0]  waddr_p1;
   logic [TAG_W:0]    wtag_p1;
   logic [LINE_W-1:0] wdata_p1;
   logic              crit_vld_p1;
   logic [BEAT_W-1:0] crit_data_p1;
   logic              fill_err_p1;
   logic              proto_err;

   // Head-address fields
   logic [BI_W-1:0]   base;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [BI_W-1:0]   slot;

   // Per-cycle beat qualification
   logic              hs;
   logic              accept;
   logic              is_final;
   logic              early_last;
   logic              late_last;
   logic              take;
   logic              done;
   logic              first;
   logic              err_next;
   logic [LINE_W-1:0] line_next;

   // Address LSBs below the beat offset and rresp[0] carry no information here.
   logic              unused_bits;
   assign unused_bits = ^{miss_addr_fifo_rdata_i, mem_rresp_i[0]};

   // A single-beat line has no slot offset field in the address.
   generate
      if (BEATS > 1) begin : g_base
         assign base = miss_addr_fifo_rdata_i[OFF_W-1:WOFF];
      end else begin : g_base_single
         assign base = '0;
      end
   endgenerate

   assign idx  = miss_addr_fifo_rdata_i[OFF_W+IDX_W-1:OFF_W];
   assign tag  = miss_addr_fifo_rdata_i[ADDR_W-1:OFF_W+IDX_W];
   // Natural BI_W-bit overflow gives the wrap-around slot order.
   assign slot = base + beat_cnt;

   // ---- stage p0: beat qualification and line merge ----
   always_comb begin
      hs         = mem_rvalid_i & mem_rready_i;
      accept     = hs & ~miss_addr_fifo_empty_i;
      is_final   = (beat_cnt == LAST_K);
      first      = (beat_cnt == '0);
      early_last = accept & mem_rlast_i & ~is_final;
      late_last  = accept & ~mem_rlast_i & is_final;
      take       = accept & ~early_last;
      done       = take & is_final;
      err_next   = err_acc | mem_rresp_i[1];
      line_next  = line_buf;
      line_next[int'(slot)*BEAT_W +: BEAT_W] = mem_rdata_i;
   end

   // The pop goes out in the final-beat cycle so the next burst sees the new head.
   assign miss_addr_fifo_rden_o = done;

   // ---- stage p1: registered write / critical-word / error outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt     <= '0;
         err_acc      <= 1'b0;
         line_buf     <= '0;
         wr_vld_p1    <= 1'b0;
         waddr_p1     <= '0;
         wtag_p1      <= '0;
         wdata_p1     <= '0;
         crit_vld_p1  <= 1'b0;
         crit_data_p1 <= '0;
         fill_err_p1  <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         wr_vld_p1   <= done;
         fill_err_p1 <= done & err_next;
         crit_vld_p1 <= take & first;

         if (take && first) begin
            crit_data_p1 <= mem_rdata_i;
         end

         // Beat on an empty FIFO, short burst, or missing rlast on the final beat.
         if ((hs && miss_addr_fifo_empty_i) || early_last || late_last) begin
            proto_err <= 1'b1;
         end

         if (early_last) begin
            beat_cnt <= '0;
            err_acc  <= 1'b0;
         end else if (done) begin
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            line_buf <= line_next;
            waddr_p1 <= idx;
            wtag_p1  <= {~err_next, tag};
            wdata_p1 <= line_next;
         end else if (take) begin
            beat_cnt <= beat_cnt + 1'b1;
            err_acc  <= err_next;
            line_buf <= line_next;
         end
      end
   end

   assign wren_o       = wr_vld_p1;
   assign waddr_o      = waddr_p1;
   assign wdata_tag_o  = wtag_p1;
   assign wdata_data_o = wdata_p1;
   assign crit_valid_o = crit_vld_p1;
   assign crit_data_o  = crit_data_p1;
   assign fill_err_o   = fill_err_p1;
   assign proto_err_o  = proto_err;

endmodule
